// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves RV32 conditional branches in execute. It holds a
// direct-mapped BTB with saturating direction counters that fetch reads, and it
// produces a registered redirect on a misprediction.
// Ports: clk/rst (async active-high reset).
//        fetch_pc_i -> pred_taken_o/pred_target_o (combinational lookup).
//        resolve_* / func3_i / src*_i / target_i / pred_*_i / flush_i -> resolve_done_o,
//        branch_taken_o, mispredict_o, redirect_pc_o (one-cycle registered pulse).
//        mispredict_count_o is a wrapping count of mispredictions.
module branch_predict_unit #(
  parameter int DataWidth = 32,
  parameter int Entries   = 16,
  parameter int CntWidth  = 2,
  parameter int IndexLsb  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  // fetch-side lookup
  input  logic [DataWidth-1:0] fetch_pc_i,
  output logic                 pred_taken_o,
  output logic [DataWidth-1:0] pred_target_o,
  // execute-side resolution
  input  logic                 resolve_valid_i,
  input  logic [DataWidth-1:0] resolve_pc_i,
  input  logic [2:0]           func3_i,
  input  logic [DataWidth-1:0] src1_i,
  input  logic [DataWidth-1:0] src2_i,
  input  logic [DataWidth-1:0] target_i,
  input  logic                 pred_taken_i,
  input  logic [DataWidth-1:0] pred_target_i,
  input  logic                 flush_i,
  // registered resolution result
  output logic                 resolve_done_o,
  output logic                 branch_taken_o,
  output logic                 mispredict_o,
  output logic [DataWidth-1:0] redirect_pc_o,
  output logic [31:0]          mispredict_count_o
);

  localparam int IdxW = $clog2(Entries);
  localparam int TagW = DataWidth - IndexLsb - IdxW;

  // Counter encodings: MSB set means "predict taken".
  localparam logic [CntWidth-1:0] CntWeakTaken    = CntWidth'(1) << (CntWidth - 1);
  localparam logic [CntWidth-1:0] CntWeakNotTaken = CntWeakTaken - CntWidth'(1);
  localparam logic [CntWidth-1:0] CntMax          = '1;
  localparam logic [CntWidth-1:0] CntMin          = '0;

  localparam logic [DataWidth-1:0] PcStep = DataWidth'(4);

  // ---------------------------------------------------------------------------
  // BTB storage
  // ---------------------------------------------------------------------------
  logic                 entry_valid  [Entries];
  logic [TagW-1:0]      entry_tag    [Entries];
  logic [DataWidth-1:0] entry_target [Entries];
  logic [CntWidth-1:0]  entry_cnt    [Entries];

  // ---------------------------------------------------------------------------
  // Fetch lookup (reads the pre-update array contents, so a same-cycle update
  // only becomes visible on the following cycle)
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] fetch_idx;
  logic [TagW-1:0] fetch_tag;
  logic            fetch_hit;

  assign fetch_idx = fetch_pc_i[IndexLsb +: IdxW];
  assign fetch_tag = fetch_pc_i[DataWidth-1 -: TagW];
  assign fetch_hit = entry_valid[fetch_idx] && (entry_tag[fetch_idx] == fetch_tag);

  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = fetch_pc_i + PcStep;
    if (fetch_hit && entry_cnt[fetch_idx][CntWidth-1]) begin
      pred_taken_o  = 1'b1;
      pred_target_o = entry_target[fetch_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Branch comparison
  // ---------------------------------------------------------------------------
  logic is_branch;
  logic cmp_taken;

  always_comb begin
    is_branch = 1'b1;
    cmp_taken = 1'b0;
    unique case (func3_i)
      3'b000:  cmp_taken = (src1_i == src2_i);
      3'b001:  cmp_taken = (src1_i != src2_i);
      3'b100:  cmp_taken = ($signed(src1_i) <  $signed(src2_i));
      3'b101:  cmp_taken = ($signed(src1_i) >= $signed(src2_i));
      3'b110:  cmp_taken = (src1_i <  src2_i);
      3'b111:  cmp_taken = (src1_i >= src2_i);
      default: is_branch = 1'b0;  // 010/011 are not branch encodings
    endcase
  end

  // ---------------------------------------------------------------------------
  // Resolution: correct next PC and misprediction check
  // ---------------------------------------------------------------------------
  logic                 res_fire;     // resolve that is allowed to have effects
  logic                 res_taken;
  logic                 res_mispredict;
  logic [DataWidth-1:0] res_next_pc;

  // A flush in the resolve cycle cancels everything the resolve would do,
  // including the pulse that would otherwise appear next cycle.
  assign res_fire       = resolve_valid_i && !flush_i;
  assign res_taken      = is_branch && cmp_taken;
  assign res_next_pc    = res_taken ? target_i : (resolve_pc_i + PcStep);
  assign res_mispredict = (res_taken != pred_taken_i) ||
                          (res_taken && (pred_target_i != target_i));

  // ---------------------------------------------------------------------------
  // Table update computation
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0]     res_idx;
  logic [TagW-1:0]     res_tag;
  logic                res_hit;
  logic                tbl_write;
  logic [CntWidth-1:0] cur_cnt;
  logic [CntWidth-1:0] new_cnt;

  assign res_idx   = resolve_pc_i[IndexLsb +: IdxW];
  assign res_tag   = resolve_pc_i[DataWidth-1 -: TagW];
  assign res_hit   = entry_valid[res_idx] && (entry_tag[res_idx] == res_tag);
  assign tbl_write = res_fire && is_branch;
  assign cur_cnt   = entry_cnt[res_idx];

  always_comb begin
    new_cnt = cur_cnt;
    if (!res_hit) begin
      // Fresh or replaced entry starts weakly biased toward the observed outcome.
      new_cnt = res_taken ? CntWeakTaken : CntWeakNotTaken;
    end else if (res_taken) begin
      if (cur_cnt != CntMax) new_cnt = cur_cnt + CntWidth'(1);
    end else begin
      if (cur_cnt != CntMin) new_cnt = cur_cnt - CntWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= '0;
        entry_cnt[i]    <= CntWeakNotTaken;
      end
    end else if (tbl_write) begin
      entry_valid[res_idx] <= 1'b1;
      entry_tag[res_idx]   <= res_tag;
      entry_cnt[res_idx]   <= new_cnt;
      // On a hit the stored target only moves when the branch was taken;
      // an allocation always records the computed target.
      if (!res_hit || res_taken) begin
        entry_target[res_idx] <= target_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered result pulse and misprediction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolve_done_o <= 1'b0;
      branch_taken_o <= 1'b0;
      mispredict_o   <= 1'b0;
      redirect_pc_o  <= '0;
    end else begin
      resolve_done_o <= res_fire;
      branch_taken_o <= res_fire && res_taken;
      mispredict_o   <= res_fire && res_mispredict;
      redirect_pc_o  <= (res_fire && res_mispredict) ? res_next_pc : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_count_o <= 32'd0;
    end else if (res_fire && res_mispredict) begin
      mispredict_count_o <= mispredict_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed resolves push expected results into a
// scoreboard queue; a negedge monitor pops and compares on every resolve_done_o pulse
// and checks the outputs are quiet otherwise. Lookups are checked directly.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        resolve_valid_i;
  logic [31:0] resolve_pc_i;
  logic [2:0]  func3_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [31:0] target_i;
  logic        pred_taken_i;
  logic [31:0] pred_target_i;
  logic        flush_i;
  logic        resolve_done_o;
  logic        branch_taken_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] mispredict_count_o;

  branch_predict_unit #(
    .DataWidth(32), .Entries(16), .CntWidth(2), .IndexLsb(2)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_pc_i(fetch_pc_i), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i), .func3_i(func3_i),
    .src1_i(src1_i), .src2_i(src2_i), .target_i(target_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i), .flush_i(flush_i),
    .resolve_done_o(resolve_done_o), .branch_taken_o(branch_taken_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .mispredict_count_o(mispredict_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic        misp;
    logic [31:0] redir;
    logic [31:0] count;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each pulse against the scoreboard, check idle outputs are zero.
  always @(negedge clk) begin
    if (resolve_done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("branch_taken", {31'd0, branch_taken_o}, {31'd0, e.taken});
        chk("mispredict", {31'd0, mispredict_o}, {31'd0, e.misp});
        chk("redirect_pc", redirect_pc_o, e.redir);
        chk("mispredict_count", mispredict_count_o, e.count);
      end
    end else begin
      chk("idle_outputs", {branch_taken_o, mispredict_o, redirect_pc_o[29:0]},
          32'd0 | {2'b00, 30'd0});
      chk("idle_redirect_hi", {30'd0, redirect_pc_o[31:30]}, 32'd0);
    end
  end

  task automatic check_pred(input logic [31:0] pc, input logic exp_t_, input logic [31:0] exp_tgt);
    fetch_pc_i = pc;
    #1;
    chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, exp_t_});
    chk("pred_target", pred_target_o, exp_tgt);
  endtask

  // Drive a resolve (inputs set now, just after a rising edge). Unless flushed or
  // discarded, the hand-computed result is queued for the monitor.
  task automatic start_res(input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                           input logic fl, input logic e_taken, input logic e_misp,
                           input logic [31:0] e_redir);
    exp_t e;
    resolve_valid_i = 1'b1;
    resolve_pc_i    = pc;
    func3_i         = f3;
    src1_i          = s1;
    src2_i          = s2;
    target_i        = tgt;
    pred_taken_i    = pt;
    pred_target_i   = ptgt;
    flush_i         = fl;
    if (!fl) begin
      if (e_misp) exp_cnt = exp_cnt + 1;
      e.taken = e_taken;
      e.misp  = e_misp;
      e.redir = e_redir;
      e.count = exp_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic end_res();
    @(posedge clk);
    #1;
    resolve_valid_i = 1'b0;
    flush_i         = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input logic e_taken, input logic e_misp, input logic [31:0] e_redir);
    start_res(pc, f3, s1, s2, tgt, pt, ptgt, 1'b0, e_taken, e_misp, e_redir);
    end_res();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_pc_i = 0; resolve_valid_i = 0; resolve_pc_i = 0; func3_i = 0;
    src1_i = 0; src2_i = 0; target_i = 0; pred_taken_i = 0; pred_target_i = 0; flush_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state, first mispredicted BEQ allocates the entry
    chk("reset_count", mispredict_count_o, 32'd0);
    chk("reset_done", {31'd0, resolve_done_o}, 32'd0);
    check_pred(32'h100, 1'b0, 32'h104);
    resolve(32'h100, 3'b000, 32'd5, 32'd5, 32'h80, 1'b0, 32'h104, 1'b1, 1'b1, 32'h80);

    // 2: correct predictions, saturation, one not-taken keeps it taken
    check_pred(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 3'b000, 32'd5, 32'd5, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    resolve(32'h100, 3'b000, 32'd5, 32'd5, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    resolve(32'h100, 3'b000, 32'd5, 32'd5, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    resolve(32'h100, 3'b000, 32'd5, 32'd6, 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h104);
    check_pred(32'h100, 1'b1, 32'h80);

    // 3: signed/unsigned compares, target mismatch, non-branch func3
    resolve(32'h204, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 32'h208, 1'b1, 1'b1, 32'h300);
    resolve(32'h208, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 32'h20C, 1'b0, 1'b0, 32'h0);
    resolve(32'h20C, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 32'h210, 1'b0, 1'b0, 32'h0);
    resolve(32'h210, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 32'h214, 1'b1, 1'b1, 32'h300);
    resolve(32'h214, 3'b001, 32'd1, 32'd2, 32'h400, 1'b1, 32'h500, 1'b1, 1'b1, 32'h400);
    resolve(32'h218, 3'b010, 32'd3, 32'd3, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h21C);
    check_pred(32'h218, 1'b0, 32'h21C);
    // miss allocates weakly-not-taken, then one taken flips it; a stray allocation
    // by the func3=010 resolve would leave it not taken
    resolve(32'h218, 3'b000, 32'd1, 32'd2, 32'h600, 1'b0, 32'h21C, 1'b0, 1'b0, 32'h0);
    resolve(32'h218, 3'b000, 32'd3, 32'd3, 32'h600, 1'b0, 32'h21C, 1'b1, 1'b1, 32'h600);
    check_pred(32'h218, 1'b1, 32'h600);

    // 4: aliasing 0x140 replaces 0x100 in index 0
    resolve(32'h140, 3'b000, 32'd7, 32'd7, 32'h90, 1'b0, 32'h144, 1'b1, 1'b1, 32'h90);
    check_pred(32'h100, 1'b0, 32'h104);
    check_pred(32'h140, 1'b1, 32'h90);

    // 5: same-cycle lookup sees old contents, new value visible next cycle
    start_res(32'h100, 3'b000, 32'd1, 32'd1, 32'hA0, 1'b0, 32'h104, 1'b0, 1'b1, 1'b1, 32'hA0);
    check_pred(32'h100, 1'b0, 32'h104);
    end_res();
    check_pred(32'h100, 1'b1, 32'hA0);

    // 6a: flushed resolve leaves table and count untouched
    start_res(32'h140, 3'b000, 32'd7, 32'd7, 32'h99, 1'b0, 32'h144, 1'b1, 1'b1, 1'b1, 32'h99);
    end_res();
    check_pred(32'h140, 1'b0, 32'h144);
    check_pred(32'h100, 1'b1, 32'hA0);
    @(posedge clk); #1;
    chk("flush_count", mispredict_count_o, exp_cnt);

    // 6b: reset asserted while a result pulse is on the outputs
    resolve_valid_i = 1'b1; resolve_pc_i = 32'h100; func3_i = 3'b000;
    src1_i = 32'd4; src2_i = 32'd4; target_i = 32'hC0; pred_taken_i = 1'b0;
    pred_target_i = 32'h104; flush_i = 1'b0;
    @(posedge clk); #1;
    resolve_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_done", {31'd0, resolve_done_o}, 32'd0);
    chk("rst_async_misp", {31'd0, mispredict_o}, 32'd0);
    chk("rst_async_count", mispredict_count_o, 32'd0);
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_pred(32'h100, 1'b0, 32'h104);
    check_pred(32'h218, 1'b0, 32'h21C);
    resolve(32'h100, 3'b000, 32'd2, 32'd2, 32'hB0, 1'b0, 32'h104, 1'b1, 1'b1, 32'hB0);
    check_pred(32'h100, 1'b1, 32'hB0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch comparator. Resolves RV32 conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) in execute.
- Adds a direct-mapped branch target buffer (BTB) with saturating-counter direction prediction, consulted by fetch.
- Detects mispredictions, produces a registered redirect to the fetch unit, and counts mispredictions.

Parameters:
DataWidth, 32, width of PC, operands and targets.
Entries, 16, BTB/counter entries; power of 2, >= 2.
CntWidth, 2, saturating counter width; >= 1.
IndexLsb, 2, lowest PC bit used for the index (word-aligned PCs).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
fetch_pc_i  input  DataWidth  PC being fetched
pred_taken_o  output  1  combinational prediction for fetch_pc_i
pred_target_o  output  DataWidth  combinational predicted next PC
resolve_valid_i  input  1  branch present in execute this cycle
resolve_pc_i  input  DataWidth  PC of the branch being resolved
func3_i  input  3  branch func3
src1_i  input  DataWidth  rs1 value
src2_i  input  DataWidth  rs2 value
target_i  input  DataWidth  computed branch target (PC+imm)
pred_taken_i  input  1  prediction carried down the pipe with the branch
pred_target_i  input  DataWidth  predicted next PC carried down the pipe
flush_i  input  1  cancel the current resolve and the pending output
resolve_done_o  output  1  registered 1-cycle pulse: resolution result valid
branch_taken_o  output  1  registered actual outcome
mispredict_o  output  1  registered; fetch must redirect
redirect_pc_o  output  DataWidth  registered correct next PC
mispredict_count_o  output  32  wrapping count of mispredictions

Behaviour:
- Index = PC[IndexLsb+log2(Entries)-1 : IndexLsb]. Tag = PC[DataWidth-1 : IndexLsb+log2(Entries)].
- Each entry holds: valid, tag, target, CntWidth-bit counter.
- Lookup (combinational):
  - Hit = valid && tag match.
  - If hit and counter MSB = 1: pred_taken_o = 1, pred_target_o = stored target.
  - Otherwise: pred_taken_o = 0, pred_target_o = fetch_pc_i + 4 (modulo 2^DataWidth).
- Compare: 000 equal; 001 not equal; 100 signed <; 101 signed >=; 110 unsigned <; 111 unsigned >=.
- func3 010/011 is not a branch: taken = 0, no table update; redirect only if pred_taken_i = 1.
- Correct next PC: taken ? target_i : resolve_pc_i + 4.
- Mispredict = (taken != pred_taken_i) || (taken && pred_target_i != target_i).
- Latency: resolve_valid_i in cycle N gives resolve_done_o, branch_taken_o, mispredict_o and redirect_pc_o in cycle N+1 for exactly one cycle.
  - All four clear to 0 in cycles with no valid resolve.
  - redirect_pc_o is 0 unless mispredict_o = 1.
- Table update at the cycle-N edge, valid func3 only:
  - Hit: counter +1 if taken (saturate at all ones), -1 if not taken (saturate at 0). Target := target_i when taken.
  - Miss: allocate or replace. valid = 1, tag written, target = target_i. Counter = 2^(CntWidth-1) if taken (weakly taken), else 2^(CntWidth-1)-1 (weakly not taken).
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents. The new value is visible the following cycle.
- mispredict_count_o increments at the cycle-N edge for each mispredicting resolve; wraps 0xFFFFFFFF -> 0.
- flush_i:
  - With resolve_valid_i in the same cycle: no table update, no count, no output next cycle.
  - While an output pulse is pending: the pulse is not raised in the next cycle. (flush_i in cycle N suppresses cycle-N+1 outputs.)
- Reset (async assert, sync-safe release):
  - All valid bits = 0, counters = 2^(CntWidth-1)-1, targets/tags = 0.
  - All registered outputs = 0, mispredict_count_o = 0.
  - Any in-flight resolve is discarded.
- CntWidth = 1: counter is 0/1; allocate taken -> 1, not taken -> 0.

Test Plan:
1. After reset, fetch_pc_i = 0x100 -> pred_taken_o = 0, pred_target_o = 0x104. Resolve BEQ at 0x100, src 5/5, target 0x80, pred 0 -> next cycle done = 1, taken = 1, mispredict = 1, redirect_pc_o = 0x80, count = 1.
2. Repeat case 1 resolve (now pred_taken_i = 1, pred_target_i = 0x80) -> mispredict = 0. Fetch 0x100 -> pred_taken_o = 1, target 0x80. Counter saturates at 3 after further taken resolves; one not-taken drops it to 2, and the prediction is still taken.
3. Signed/unsigned: src1 = 0xFFFFFFFF, src2 = 1. BLT taken, BGE not, BLTU not, BGEU taken. func3 = 010 with pred 1 -> mispredict, redirect = pc+4, no table allocation.
4. Aliasing: PCs 0x100 and 0x140 (Entries = 16) share an index with different tags. Resolve 0x140 taken -> fetch 0x100 is a miss (pred 0); fetch 0x140 hits.
5. Same-cycle fetch and update of 0x100 -> fetch sees the old prediction; the next cycle sees the new one.
6. flush_i with resolve_valid_i, and rst asserted mid-stream -> no output pulse, table and count unchanged by the flushed resolve. Reset clears all outputs, entries and the count asynchronously.
